jk_excitation_driver: RTL

Controller that drives a bank of WIDTH level-sensitive JK latch cells toward a requested target value. It accepts a target word over a valid/ready handshake and computes the J/K excitation per bit from the current cell outputs. It then pulses the shared enable, waits for settling, and reads back q to confirm. It sits on the write side of the JK storage cells and is the only agent allowed to drive their j, k and en inputs.

---
 rtl/jk_excitation_driver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/jk_excitation_driver.sv
// Write-side controller for a bank of level-sensitive JK latch cells: computes per-bit
// J/K excitation toward a requested word, pulses the shared enable, settles, and verifies.
module jk_excitation_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);

  state_t           state;
  logic [WIDTH-1:0] tgt_r;
  logic [WIDTH-1:0] q_meta;
  logic [WIDTH-1:0] q_s;
  logic [SW-1:0]    settle_cnt;
  logic [RW-1:0]    retry;

  logic [WIDTH-1:0] exc_t;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;

  // Set only bits that must rise, clear only bits that must fall; j&k is never formed,
  // since toggling a transparent latch races.
  assign exc_t = (state == IDLE) ? tgt_data : tgt_r;
  assign exc_j = exc_t & ~q_s;
  assign exc_k = ~exc_t & q_s;

  // NOTE: ready is gated by rst_n so it reads 0 while reset is held, not only after release.
  assign tgt_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);

  // NOTE: every register here uses non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tgt_r      <= '0;
      q_meta     <= '0;
      q_s        <= '0;
      settle_cnt <= '0;
      retry      <= '0;
      j          <= '0;
      k          <= '0;
      en         <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_mask   <= '0;
    end else begin
      q_meta <= q_fb;
      q_s    <= q_meta;
      done   <= 1'b0;
      err    <= 1'b0;

      case (state)
        IDLE: begin
          if (tgt_valid) begin
            tgt_r    <= tgt_data;
            j        <= exc_j;
            k        <= exc_k;
            en       <= 1'b1;
            retry    <= '0;
            err_mask <= '0;
            state    <= DRIVE;
          end
        end

        DRIVE: begin
          en         <= 1'b0;
          j          <= '0;
          k          <= '0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        CHECK: begin
          if (q_s == tgt_r) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (retry < RETRY_LAST) begin
            retry <= retry + 1'b1;
            j     <= exc_j;
            k     <= exc_k;
            en    <= 1'b1;
            state <= DRIVE;
          end else begin
            err_mask <= q_s ^ tgt_r;
            err      <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
